bsr_chain: RTL

//  Parametrised boundary-scan register: WIDTH scan cells, each a shift flop plus an update flop.

---
 rtl/bsr_pkg.sv | 10 +
 rtl/bsr_cell.sv | 52 +++++
 rtl/bsr_chain.sv | 57 +++++
 3 files changed

// File: rtl/bsr_pkg.sv
// rtl/bsr_pkg.sv - shared encodings for the boundary-scan register chain
// Contents:
//   MODE_NORMAL  par_out driven from par_in
//   MODE_TEST    par_out driven from the update register
package bsr_pkg;

    localparam logic MODE_NORMAL = 1'b0;
    localparam logic MODE_TEST   = 1'b1;

endpackage

// File: rtl/bsr_cell.sv
// rtl/bsr_cell.sv - one boundary-scan cell: shift flop, update flop and output mode mux
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   si           serial input from the neighbouring cell (or tdi)
//   pi           parallel input from core/pin
//   capture_en   load pi into the shift flop (wins over shift_en)
//   shift_en     load si into the shift flop
//   update_en    copy the shift flop into the update flop
//   mode         MODE_NORMAL: po = pi, MODE_TEST: po = uq
//   rst_val      reset value for both flops
//   so           shift flop (serial output toward tdo)
//   po           parallel output to pin/core
//   uq           update flop
module bsr_cell
    import bsr_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic si,
    input  logic pi,
    input  logic capture_en,
    input  logic shift_en,
    input  logic update_en,
    input  logic mode,
    input  logic rst_val,
    output logic so,
    output logic po,
    output logic uq
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            so <= rst_val;
        end else if (capture_en) begin
            so <= pi;
        end else if (shift_en) begin
            so <= si;
        end
    end

    // Samples the shift flop before this edge's capture/shift lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uq <= rst_val;
        end else if (update_en) begin
            uq <= so;
        end
    end

    assign po = (mode == MODE_TEST) ? uq : pi;

endmodule

// File: rtl/bsr_chain.sv
// rtl/bsr_chain.sv - WIDTH-cell boundary-scan register, shifting from tdi toward tdo
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   tdi          serial scan data in (enters the top cell)
//   capture_en   load par_in into the shift register
//   shift_en     shift one bit toward tdo
//   update_en    copy the shift register into the update register
//   mode         0 = par_out follows par_in, 1 = par_out follows upd_q
//   par_in       parallel data from core/pins
//   par_out      parallel data to pins/core
//   upd_q        update register contents
//   tdo          serial scan data out, shift register bit 0
module bsr_chain
    import bsr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tdi,
    input  logic             capture_en,
    input  logic             shift_en,
    input  logic             update_en,
    input  logic             mode,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] par_out,
    output logic [WIDTH-1:0] upd_q,
    output logic             tdo
);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] ser_in;

    // Each cell takes its serial input from the cell above; the top cell takes tdi.
    assign ser_in = {tdi, sr[WIDTH-1:1]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        bsr_cell u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .si         (ser_in[i]),
            .pi         (par_in[i]),
            .capture_en (capture_en),
            .shift_en   (shift_en),
            .update_en  (update_en),
            .mode       (mode),
            .rst_val    (RESET_VAL[i]),
            .so         (sr[i]),
            .po         (par_out[i]),
            .uq         (upd_q[i])
        );
    end

    assign tdo = sr[0];

endmodule
